// File: rtl/sample_scheduler_if.sv
// Sample stream from the scheduler to a downstream sink (logger, DAC, UART bridge).
// One beat per channel; out_last marks the final channel of a frame.
interface sample_scheduler_if #(
  parameter int BITS = 16,
  parameter int CHW  = 2
);
  logic [BITS-1:0] out_data;
  logic [CHW-1:0]  out_chan;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;

  modport master (output out_data, output out_chan, output out_last, output out_valid,
                  input out_ready);
  modport slave  (input out_data, input out_chan, input out_last, input out_valid,
                  output out_ready);
endinterface

// File: rtl/sample_scheduler.sv
// Sample-rate strobe generator and multi-channel frame sequencer: snapshots all channels on
// each strobe and streams them out one beat per channel, for a programmed number of frames.
module sample_scheduler #(
  parameter int CLK_FREQ   = 50000000,
  parameter int SAMPLERATE = 6400,
  parameter int BITS       = 16,
  parameter int CHANNELS   = 4,
  parameter int ROWS       = 64000,
  localparam int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int RW        = $clog2(ROWS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BITS*CHANNELS-1:0] in_data,
  output logic                     tick,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic [RW-1:0]            row_count,
  sample_scheduler_if.master       stream
);

  localparam int ACC_W = $clog2(CLK_FREQ + SAMPLERATE);
  localparam logic [ACC_W-1:0] SR_W    = ACC_W'(SAMPLERATE);
  localparam logic [ACC_W-1:0] CF_W    = ACC_W'(CLK_FREQ);
  localparam logic [CHW-1:0]   LAST_CH = CHW'(CHANNELS - 1);
  localparam logic [RW-1:0]    ROWS_W  = RW'(ROWS);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, EMIT, DONE} state_t;

  state_t                   state, state_n;
  logic [ACC_W-1:0]         acc, acc_n, acc_sum;
  logic                     wrap, tick_n;
  logic [BITS*CHANNELS-1:0] snap, snap_n;
  logic [CHW-1:0]           ch, ch_n;
  logic                     valid, valid_n, last, last_n;
  logic [BITS-1:0]          data, data_n;
  logic                     busy_n, done_n, overrun_n;
  logic [RW-1:0]            row_n;

  always_comb begin
    // NOTE: every next-value variable is defaulted first so no path can infer a latch.
    state_n   = state;
    acc_n     = acc;
    tick_n    = 1'b0;
    snap_n    = snap;
    ch_n      = ch;
    valid_n   = valid;
    data_n    = data;
    last_n    = last;
    busy_n    = busy;
    done_n    = done;
    overrun_n = overrun;
    row_n     = row_count;
    acc_sum   = acc + SR_W;
    wrap      = (acc_sum >= CF_W);

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = WAIT_TICK;
          acc_n     = '0;
          row_n     = '0;
          overrun_n = 1'b0;
          done_n    = 1'b0;
          busy_n    = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          snap_n  = in_data;
          ch_n    = '0;
          valid_n = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        // A strobe arriving mid-frame is dropped; only the sticky flag records it.
        if (tick) overrun_n = 1'b1;
        if (stream.out_ready) begin
          if (ch == LAST_CH) begin
            row_n   = row_count + 1'b1;
            valid_n = 1'b0;
            if (row_n == ROWS_W) begin
              state_n = DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = WAIT_TICK;
            end
          end else begin
            ch_n = ch + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Phase accumulator: remainder is carried over, so the long-term rate is exact.
    if (busy && busy_n) begin
      tick_n = wrap;
      acc_n  = wrap ? (acc_sum - CF_W) : acc_sum;
    end

    if (valid_n) begin
      data_n = snap_n[BITS*int'(ch_n) +: BITS];
      last_n = (ch_n == LAST_CH);
    end else begin
      last_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tick      <= 1'b0;
      ch        <= '0;
      valid     <= 1'b0;
      data      <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      row_count <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      tick      <= tick_n;
      ch        <= ch_n;
      valid     <= valid_n;
      data      <= data_n;
      last      <= last_n;
      busy      <= busy_n;
      done      <= done_n;
      overrun   <= overrun_n;
      row_count <= row_n;
    end
  end

  // NOTE: the snapshot is pure data qualified by out_valid, so it is deliberately not reset.
  always_ff @(posedge clk) snap <= snap_n;

  assign stream.out_data  = data;
  assign stream.out_chan  = ch;
  assign stream.out_last  = last;
  assign stream.out_valid = valid;

endmodule
